// File: rtl/core_ifu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ifu_pkg : shared core defines (NOP, IFU states, PC increment)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_ifu_pkg;

  localparam logic [31:0] C_NOP     = 32'h00000013;
  localparam logic [31:0] C_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } ifu_state_e;

  // Wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + C_PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_ifu_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ifu_skid : one-entry data+valid buffer with load/clear/pop      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module core_ifu_skid
  import core_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_pop,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_valid;

  // Clear has priority so a flush always leaves the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= C_NOP;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/core_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_ifu : instruction fetch unit, one outstanding IMEM request,     |
// |            IF/ID register with skid buffer for stalls                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module core_ifu
  import core_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        HCU_PC_WRITE,
  input  logic        HCU_IDEX_FLUSH,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_ARVALID,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_ARREADY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IFID_VALID,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_run;

  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;

  logic        w_arvalid;
  logic        w_accept;
  logic        w_ifid_load;
  logic [31:0] w_ifid_data;
  logic        w_skid_load;
  logic        w_skid_pop;
  logic        w_skid_clear;
  logic [31:0] w_skid_data;
  logic        w_skid_valid;

  // r_run keeps the request line low until the first edge after reset.
  assign w_arvalid = r_run && (r_state == S_REQ);
  assign w_accept  = w_arvalid && IMEM_ARREADY;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ifid_load  = 1'b0;
    w_ifid_data  = IMEM_RDATA;
    w_skid_load  = 1'b0;
    w_skid_pop   = 1'b0;
    w_skid_clear = 1'b0;

    if (HCU_IDEX_FLUSH) begin
      w_pc_nxt     = {REDIRECT_PC[31:2], 2'b00};
      w_skid_clear = 1'b1;
      unique case (r_state)
        S_REQ:   if (w_accept) w_state_nxt = S_DRAIN;
        S_WAIT:  w_state_nxt = IMEM_RVALID ? S_REQ : S_DRAIN;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DRAIN: if (IMEM_RVALID) w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_accept) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_RVALID) begin
            if (HCU_PC_WRITE) begin
              w_ifid_load = 1'b1;
              w_pc_nxt    = pc_inc(r_pc);
              w_state_nxt = S_REQ;
            end else begin
              w_skid_load = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (HCU_PC_WRITE && w_skid_valid) begin
            w_ifid_load = 1'b1;
            w_ifid_data = w_skid_data;
            w_skid_pop  = 1'b1;
            w_pc_nxt    = pc_inc(r_pc);
            w_state_nxt = S_REQ;
          end
        end
        S_DRAIN: begin
          if (IMEM_RVALID) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // A load can only happen while PC_WRITE=1, so otherwise IF/ID holds.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= C_NOP;
      r_ifid_pc    <= 32'h00000000;
    end else if (HCU_IDEX_FLUSH) begin
      r_ifid_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_ifid_valid <= 1'b1;
      r_ifid_instr <= w_ifid_data;
      r_ifid_pc    <= r_pc;
    end else if (HCU_PC_WRITE) begin
      r_ifid_valid <= 1'b0;
    end
  end

  core_ifu_skid u_skid (
    .clk     (CLK),
    .rst_n   (NRST),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pop   (w_skid_pop),
    .i_data  (IMEM_RDATA),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  assign IMEM_ARVALID = w_arvalid;
  assign IMEM_ARADDR  = r_pc;
  assign IFID_VALID   = r_ifid_valid;
  assign IFID_INSTR   = r_ifid_instr;
  assign IFID_PC      = r_ifid_pc;

endmodule
`default_nettype wire

// File: tb/tb_core_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_ifu : directed self-checking bench for core_ifu              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_core_ifu;

  localparam logic [31:0] C_XOR = 32'hA5A5A5A5;

  logic        CLK;
  logic        NRST;
  logic        pc_write;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  // Second instance exercises the wrap-around reset PC.
  logic        d2_pc_write;
  logic        d2_flush;
  logic [31:0] d2_redirect;
  logic        d2_arvalid;
  logic [31:0] d2_araddr;
  logic        d2_rvalid;
  logic        d2_ifid_valid;
  logic [31:0] d2_ifid_instr;
  logic [31:0] d2_ifid_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic        mem_pend;
  int          mem_cnt;
  int          mem_delay;
  logic [31:0] mem_addr;

  core_ifu u_dut (
    .CLK            (CLK),
    .NRST           (NRST),
    .HCU_PC_WRITE   (pc_write),
    .HCU_IDEX_FLUSH (flush),
    .REDIRECT_PC    (redirect_pc),
    .IMEM_ARVALID   (arvalid),
    .IMEM_ARADDR    (araddr),
    .IMEM_ARREADY   (arready),
    .IMEM_RVALID    (rvalid),
    .IMEM_RDATA     (rdata),
    .IFID_VALID     (ifid_valid),
    .IFID_INSTR     (ifid_instr),
    .IFID_PC        (ifid_pc)
  );

  core_ifu #(.RESET_PC(32'hFFFFFFFC)) u_dut_wrap (
    .CLK            (CLK),
    .NRST           (NRST),
    .HCU_PC_WRITE   (d2_pc_write),
    .HCU_IDEX_FLUSH (d2_flush),
    .REDIRECT_PC    (d2_redirect),
    .IMEM_ARVALID   (d2_arvalid),
    .IMEM_ARADDR    (d2_araddr),
    .IMEM_ARREADY   (1'b1),
    .IMEM_RVALID    (d2_rvalid),
    .IMEM_RDATA     (32'h00000013),
    .IFID_VALID     (d2_ifid_valid),
    .IFID_INSTR     (d2_ifid_instr),
    .IFID_PC        (d2_ifid_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: answers mem_delay cycles after the accepting edge.
  assign rvalid = mem_pend && (mem_cnt == 0);
  assign rdata  = mem_addr ^ C_XOR;

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 32'h0;
    end else begin
      if (rvalid) mem_pend <= 1'b0;
      else if (mem_pend && mem_cnt > 0) mem_cnt <= mem_cnt - 1;
      if (arvalid && arready) begin
        mem_pend <= 1'b1;
        mem_cnt  <= mem_delay;
        mem_addr <= araddr;
      end
    end
  end

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) d2_rvalid <= 1'b0;
    else       d2_rvalid <= d2_arvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_arvalid(input int max_cycles);
    for (int i = 0; i < max_cycles && !arvalid; i++) @(negedge CLK);
    check("arvalid_timeout", {31'd0, arvalid}, 32'd1);
  endtask

  initial begin
    NRST        = 1'b0;
    pc_write    = 1'b1;
    flush       = 1'b0;
    redirect_pc = 32'h0;
    arready     = 1'b1;
    mem_delay   = 0;
    d2_pc_write = 1'b1;
    d2_flush    = 1'b0;
    d2_redirect = 32'h0;

    repeat (2) @(negedge CLK);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'h00000013);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_wrap_araddr", d2_araddr, 32'hFFFFFFFC);
    NRST = 1'b1;

    // Back-to-back fetches: one instruction every two cycles.
    @(negedge CLK);
    check("first_arvalid", {31'd0, arvalid}, 32'd1);
    check("first_araddr", araddr, 32'h0);
    check("wrap_arvalid", {31'd0, d2_arvalid}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge CLK);
      check("seq_valid", {31'd0, ifid_valid}, 32'd1);
      check("seq_pc", ifid_pc, 32'(4 * k));
      check("seq_instr", ifid_instr, 32'(4 * k) ^ C_XOR);
      if (k == 0) begin
        check("seq_next_addr", araddr, 32'h4);
        check("wrap_ifid_pc", d2_ifid_pc, 32'hFFFFFFFC);
        check("wrap_second_addr", d2_araddr, 32'h00000000);
      end
      if (k == 1) begin
        @(negedge CLK);
        check("seq_bubble", {31'd0, ifid_valid}, 32'd0);
        @(negedge CLK);
        check("seq_pc_k2", ifid_pc, 32'h8);
        @(negedge CLK);
        check("seq_bubble2", {31'd0, ifid_valid}, 32'd0);
        @(negedge CLK);
        check("seq_pc_k3", ifid_pc, 32'hC);
        break;
      end
    end

    // Stall for five edges while the word for PC 16 returns.
    pc_write = 1'b0;
    @(negedge CLK);
    check("stall_valid", {31'd0, ifid_valid}, 32'd1);
    check("stall_pc", ifid_pc, 32'hC);
    repeat (2) @(negedge CLK);
    check("stall_hold_arvalid", {31'd0, arvalid}, 32'd0);
    check("stall_frozen_pc", ifid_pc, 32'hC);
    check("stall_frozen_instr", ifid_instr, 32'hC ^ C_XOR);
    repeat (2) @(negedge CLK);
    pc_write = 1'b1;
    @(negedge CLK);
    check("release_valid", {31'd0, ifid_valid}, 32'd1);
    check("release_pc", ifid_pc, 32'h10);
    check("release_instr", ifid_instr, 32'h10 ^ C_XOR);
    check("release_araddr", araddr, 32'h14);

    // Flush while waiting; late data must be dropped.
    mem_delay = 3;
    @(negedge CLK);
    flush       = 1'b1;
    redirect_pc = 32'h00000103;
    @(negedge CLK);
    flush = 1'b0;
    check("drain_valid", {31'd0, ifid_valid}, 32'd0);
    check("drain_arvalid", {31'd0, arvalid}, 32'd0);
    mem_delay = 0;
    wait_arvalid(10);
    check("redirect_araddr", araddr, 32'h00000100);
    check("redirect_valid", {31'd0, ifid_valid}, 32'd0);
    repeat (2) @(negedge CLK);
    check("redirect_load_pc", ifid_pc, 32'h100);
    check("redirect_load_instr", ifid_instr, 32'h100 ^ C_XOR);

    // Flush coincident with RVALID and PC_WRITE=1.
    @(negedge CLK);
    check("coinc_rvalid", {31'd0, rvalid}, 32'd1);
    flush       = 1'b1;
    redirect_pc = 32'h00000200;
    @(negedge CLK);
    flush = 1'b0;
    check("coinc_valid", {31'd0, ifid_valid}, 32'd0);
    check("coinc_ifid_pc", ifid_pc, 32'h100);
    check("coinc_araddr", araddr, 32'h200);
    repeat (2) @(negedge CLK);
    check("coinc_load_pc", ifid_pc, 32'h200);

    // Flush in S_REQ with ARREADY low: address retargets in place.
    arready     = 1'b0;
    flush       = 1'b1;
    redirect_pc = 32'h00000300;
    @(negedge CLK);
    flush   = 1'b0;
    arready = 1'b1;
    check("req_flush_arvalid", {31'd0, arvalid}, 32'd1);
    check("req_flush_araddr", araddr, 32'h300);
    repeat (2) @(negedge CLK);
    check("req_flush_load_pc", ifid_pc, 32'h300);

    // Reset while a request is outstanding.
    mem_delay = 5;
    @(negedge CLK);
    NRST = 1'b0;
    #1;
    check("arst_arvalid", {31'd0, arvalid}, 32'd0);
    check("arst_araddr", araddr, 32'h0);
    check("arst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_ifid_instr", ifid_instr, 32'h00000013);
    check("arst_ifid_pc", ifid_pc, 32'h0);
    @(negedge CLK);
    NRST      = 1'b1;
    mem_delay = 0;
    @(negedge CLK);
    check("restart_araddr", araddr, 32'h0);
    check("restart_arvalid", {31'd0, arvalid}, 32'd1);
    repeat (2) @(negedge CLK);
    check("restart_valid", {31'd0, ifid_valid}, 32'd1);
    check("restart_instr", ifid_instr, C_XOR);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_ifu.md
CORE_IFU -- requirements
Module: core_ifu

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL provide ports:
- CLK  in  1  single clock; all state changes on rising edge.
- NRST  in  1  reset, asynchronous, active-low.
- HCU_PC_WRITE  in  1  1 = IF/ID may advance; 0 = stall.
- HCU_IDEX_FLUSH  in  1  redirect/flush request.
- REDIRECT_PC  in  32  redirect target; sampled when HCU_IDEX_FLUSH=1.
- IMEM_ARVALID  out  1  fetch request valid.
- IMEM_ARADDR  out  32  fetch address.
- IMEM_ARREADY  in  1  request accepted.
- IMEM_RVALID  in  1  instruction data valid.
- IMEM_RDATA  in  32  instruction word.
- IFID_VALID  out  1  IF/ID holds a live instruction.
- IFID_INSTR  out  32  IF/ID instruction.
- IFID_PC  out  32  address of IFID_INSTR.

Function
REQ-003 SHALL keep at most one IMEM request outstanding.
REQ-004 SHALL implement states S_REQ, S_WAIT, S_HOLD, S_DRAIN.
REQ-005 In S_REQ: IMEM_ARVALID=1 and IMEM_ARADDR=PC; on ARREADY go to S_WAIT.
REQ-006 In S_WAIT, on RVALID with HCU_PC_WRITE=1: load IF/ID with {PC, RDATA}, set IFID_VALID=1, PC<=PC+4, and go to S_REQ.
REQ-007 In S_WAIT, on RVALID with HCU_PC_WRITE=0: capture RDATA in the skid buffer, leave IF/ID unchanged, and go to S_HOLD.
REQ-008 In S_HOLD, when HCU_PC_WRITE=1: move the skid buffer into IF/ID, set IFID_VALID=1, PC<=PC+4, and go to S_REQ.
REQ-009 When HCU_PC_WRITE=1 and no fetched word is available that cycle, IFID_VALID SHALL become 0 (bubble).
REQ-010 When HCU_PC_WRITE=0, IF/ID SHALL hold all values unchanged.
REQ-011 HCU_IDEX_FLUSH=1 SHALL override HCU_PC_WRITE: IFID_VALID<=0, skid buffer cleared, PC<={REDIRECT_PC[31:2],2'b00}.
REQ-012 Flush in S_REQ without ARREADY: stay in S_REQ; IMEM_ARADDR shows the new PC next cycle. IMEM_ARVALID may drop only in this case.
REQ-013 Flush in S_REQ with ARREADY, or in S_WAIT without RVALID: go to S_DRAIN.
REQ-014 Flush in S_WAIT with RVALID, or in S_HOLD: discard the data and go to S_REQ.
REQ-015 In S_DRAIN: IMEM_ARVALID=0; on RVALID discard the data and go to S_REQ. A further flush here only updates PC.
REQ-016 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-017 Best-case latency: request accepted cycle N, RVALID at N+1, IFID_VALID=1 from N+2. Peak throughput is 1 instruction per 2 cycles.
REQ-018 IMEM_RDATA SHALL be ignored outside S_WAIT/S_DRAIN; RVALID in S_REQ/S_HOLD is a protocol error with no state effect.

Reset
REQ-019 While NRST=0: state=S_REQ, PC=RESET_PC, IMEM_ARVALID=0, IMEM_ARADDR=RESET_PC, IFID_VALID=0, IFID_INSTR=32'h00000013, IFID_PC=32'h00000000, skid buffer empty.
REQ-020 IMEM_ARVALID SHALL first assert in the first cycle after NRST deasserts.
REQ-021 Reset mid-fetch SHALL abandon the outstanding request with no drain. The memory side is reset on the same NRST.

Structure
REQ-022 NOP encoding (32'h00000013), state encodings and the PC increment SHALL live in the shared core defines file used by the pipeline blocks.
REQ-023 The skid buffer SHALL be a sub-module core_ifu_skid: 1-entry data+valid register with load/clear/pop inputs.
REQ-024 core_ifu SHALL connect directly to core_hcu outputs HCU_PC_WRITE and HCU_IDEX_FLUSH with no glue logic.

Verification
REQ-025 Reset, then ARREADY=1 always, RVALID one cycle after accept, RDATA=PC^32'hA5A5A5A5 -> IFID_PC sequence 0,4,8,12 with a new value every 2 cycles.
REQ-026 HCU_PC_WRITE=0 for 5 cycles while RVALID arrives -> IF/ID frozen, skid holds word; on release IFID_INSTR=held word, next ARADDR=PC+4.
REQ-027 Flush with REDIRECT_PC=32'h00000103 while in S_WAIT -> late RDATA discarded, IFID_VALID=0, next ARADDR=32'h00000100.
REQ-028 Flush the same cycle as RVALID and HCU_PC_WRITE=1 -> no IF/ID load, IFID_VALID=0, ARADDR=REDIRECT_PC next cycle.
REQ-029 RESET_PC=32'hFFFFFFFC -> second fetch address is 32'h00000000.
REQ-030 NRST pulsed low while in S_WAIT -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.
